bus16_arbiter_2m: RTL and testbench

Two-master arbiter and sequencer for the 16-bit FPGA bus that fronts the 16-register bus register banks. It accepts whole read or write transactions from two requesters, for example a UART command decoder and a SPI slave. It grants them round-robin and drives exactly one bus cycle per transaction. It then returns write completion, read data, or a read-timeout error to the granted master.

---
 rtl/bus16_pkg.sv | 20 ++
 rtl/bus16_timeout_ctr.sv | 45 ++++
 rtl/bus16_arbiter_2m.sv | 185 ++++++++++++++++++
 tb/tb_bus16_arbiter_2m.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus16_pkg.sv
// bus16_pkg: definitions shared by the 16-bit FPGA bus blocks.
//   - bus16_state_e : sequencer states for bus16_arbiter_2m
//   - M0 / M1       : master index constants
//   - BusDataW / BusAddrW : bus data and address widths, also used by the register banks
package bus16_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StWaitRd = 2'd2,
      StDone   = 2'd3
   } bus16_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int unsigned BusDataW = 16;
   localparam int unsigned BusAddrW = 5;

endpackage

// File: rtl/bus16_timeout_ctr.sv
// bus16_timeout_ctr: read-timeout counter for the bus sequencer.
//   i_Bus_Clk   : bus clock
//   i_Bus_Rst_L : asynchronous active-low reset
//   i_Clear     : synchronous clear to 0 (takes priority over i_Enable)
//   i_Enable    : count one waited cycle
//   o_Expired   : the current waited cycle is the last one allowed
module bus16_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic i_Bus_Clk,
   input  logic i_Bus_Rst_L,
   input  logic i_Clear,
   input  logic i_Enable,
   output logic o_Expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_Clear) begin
         cnt_d = '0;
      end else if (i_Enable && (cnt_q != MaxCnt)) begin
         // saturate rather than wrap
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counted value reaches TIMEOUT_CYCLES on the edge ending this cycle.
   assign o_Expired = (cnt_q == LastCnt);

endmodule

// File: rtl/bus16_arbiter_2m.sv
// bus16_arbiter_2m: two-master round-robin arbiter and single-cycle bus sequencer.
//   i_Bus_Clk, i_Bus_Rst_L          : clock, asynchronous active-low reset
//   i_Mx_Req/Wr_Rd_n/Addr8/Wr_Data  : per-master transaction request, held until Ack
//   o_Mx_Ack/Err/Rd_Data            : per-master completion pulse, read timeout, read data
//   o_Bus_CS/Wr_Rd_n/Addr8/Wr_Data  : bus cycle outputs, CS high one cycle per transaction
//   i_Bus_Rd_Data/i_Bus_Rd_DV       : slave read return
module bus16_arbiter_2m
   import bus16_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                i_Bus_Clk,
   input  logic                i_Bus_Rst_L,
   input  logic                i_M0_Req,
   input  logic                i_M0_Wr_Rd_n,
   input  logic [BusAddrW-1:0] i_M0_Addr8,
   input  logic [BusDataW-1:0] i_M0_Wr_Data,
   output logic                o_M0_Ack,
   output logic                o_M0_Err,
   output logic [BusDataW-1:0] o_M0_Rd_Data,
   input  logic                i_M1_Req,
   input  logic                i_M1_Wr_Rd_n,
   input  logic [BusAddrW-1:0] i_M1_Addr8,
   input  logic [BusDataW-1:0] i_M1_Wr_Data,
   output logic                o_M1_Ack,
   output logic                o_M1_Err,
   output logic [BusDataW-1:0] o_M1_Rd_Data,
   output logic                o_Bus_CS,
   output logic                o_Bus_Wr_Rd_n,
   output logic [BusAddrW-1:0] o_Bus_Addr8,
   output logic [BusDataW-1:0] o_Bus_Wr_Data,
   input  logic [BusDataW-1:0] i_Bus_Rd_Data,
   input  logic                i_Bus_Rd_DV
);

   bus16_state_e        state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;
   logic                cs_q, cs_d;
   logic                bus_wr_rd_n_q, bus_wr_rd_n_d;
   logic [BusAddrW-1:0] bus_addr_q, bus_addr_d;
   logic [BusDataW-1:0] bus_wr_data_q, bus_wr_data_d;
   logic [1:0]          ack_q, ack_d;
   logic [1:0]          err_q, err_d;
   logic [BusDataW-1:0] m0_rd_data_q, m0_rd_data_d;
   logic [BusDataW-1:0] m1_rd_data_q, m1_rd_data_d;

   logic ctr_clear;
   logic ctr_enable;
   logic ctr_expired;

   bus16_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .i_Bus_Clk   (i_Bus_Clk),
      .i_Bus_Rst_L (i_Bus_Rst_L),
      .i_Clear     (ctr_clear),
      .i_Enable    (ctr_enable),
      .o_Expired   (ctr_expired)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      cs_d          = 1'b0;
      bus_wr_rd_n_d = bus_wr_rd_n_q;
      bus_addr_d    = bus_addr_q;
      bus_wr_data_d = bus_wr_data_q;
      ack_d         = 2'b00;
      err_d         = 2'b00;
      m0_rd_data_d  = m0_rd_data_q;
      m1_rd_data_d  = m1_rd_data_q;
      ctr_clear     = 1'b0;
      ctr_enable    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_M0_Req || i_M1_Req) begin
               // On a tie the master not granted last time wins.
               if (i_M0_Req && i_M1_Req) begin
                  grant_d = ~last_q;
               end else begin
                  grant_d = i_M1_Req ? M1 : M0;
               end
               last_d = grant_d;
               cs_d   = 1'b1;
               if (grant_d == M1) begin
                  bus_wr_rd_n_d = i_M1_Wr_Rd_n;
                  bus_addr_d    = i_M1_Addr8;
                  bus_wr_data_d = i_M1_Wr_Data;
               end else begin
                  bus_wr_rd_n_d = i_M0_Wr_Rd_n;
                  bus_addr_d    = i_M0_Addr8;
                  bus_wr_data_d = i_M0_Wr_Data;
               end
               state_d = StIssue;
            end
         end

         StIssue: begin
            if (bus_wr_rd_n_q) begin
               ack_d[grant_q] = 1'b1;
               state_d        = StDone;
            end else begin
               ctr_clear = 1'b1;
               state_d   = StWaitRd;
            end
         end

         StWaitRd: begin
            // DV is checked first so it wins on the last counted cycle.
            if (i_Bus_Rd_DV) begin
               if (grant_q == M1) begin
                  m1_rd_data_d = i_Bus_Rd_Data;
               end else begin
                  m0_rd_data_d = i_Bus_Rd_Data;
               end
               ack_d[grant_q] = 1'b1;
               state_d        = StDone;
            end else begin
               ctr_enable = 1'b1;
               if (ctr_expired) begin
                  if (grant_q == M1) begin
                     m1_rd_data_d = '0;
                  end else begin
                     m0_rd_data_d = '0;
                  end
                  ack_d[grant_q] = 1'b1;
                  err_d[grant_q] = 1'b1;
                  state_d        = StDone;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         state_q       <= StIdle;
         grant_q       <= M0;
         last_q        <= M1;
         cs_q          <= 1'b0;
         bus_wr_rd_n_q <= 1'b0;
         bus_addr_q    <= '0;
         bus_wr_data_q <= '0;
         ack_q         <= 2'b00;
         err_q         <= 2'b00;
         m0_rd_data_q  <= '0;
         m1_rd_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         cs_q          <= cs_d;
         bus_wr_rd_n_q <= bus_wr_rd_n_d;
         bus_addr_q    <= bus_addr_d;
         bus_wr_data_q <= bus_wr_data_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         m0_rd_data_q  <= m0_rd_data_d;
         m1_rd_data_q  <= m1_rd_data_d;
      end
   end

   assign o_M0_Ack      = ack_q[0];
   assign o_M1_Ack      = ack_q[1];
   assign o_M0_Err      = err_q[0];
   assign o_M1_Err      = err_q[1];
   assign o_M0_Rd_Data  = m0_rd_data_q;
   assign o_M1_Rd_Data  = m1_rd_data_q;
   assign o_Bus_CS      = cs_q;
   assign o_Bus_Wr_Rd_n = bus_wr_rd_n_q;
   assign o_Bus_Addr8   = bus_addr_q;
   assign o_Bus_Wr_Data = bus_wr_data_q;

endmodule

// File: tb/tb_bus16_arbiter_2m.sv
// tb_bus16_arbiter_2m: bench for bus16_arbiter_2m. A transaction-level model predicts grant
// order, CS cycle, Ack cycle, Err and Rd_Data; directed table entries plus random vectors.
module tb_bus16_arbiter_2m;

   localparam int T = 15;

   typedef struct {
      logic        req0, req1;
      logic        wr0, wr1;
      logic [4:0]  addr0, addr1;
      logic [15:0] wdata0, wdata1;
      int          dvd0, dvd1;    // DV delay after CS in cycles, 0 = never
      logic [15:0] rdata0, rdata1;
      int          nrep;          // transactions per requesting master
      logic        stray;         // DV pulse in the starting IDLE cycle
      int          exp_first;     // master of first Ack, -1 = unchecked
      int          exp_lat;       // cycles from Req seen to first Ack
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m_req [2];
   logic        m_wr [2];
   logic [4:0]  m_addr [2];
   logic [15:0] m_wdata [2];
   logic        ack0, ack1, err0, err1;
   logic [15:0] rd0, rd1;
   logic        cs, bwr;
   logic [4:0]  baddr;
   logic [15:0] bwdata, brdata;
   logic        bdv;

   int          total, bad;
   int          model_last;
   logic [15:0] rd_hold [2];
   logic        hold_wr;
   logic [4:0]  hold_addr;
   logic [15:0] hold_wdata;

   always #5 clk = ~clk;

   bus16_arbiter_2m #(
      .TIMEOUT_CYCLES (T)
   ) dut (
      .i_Bus_Clk     (clk),
      .i_Bus_Rst_L   (rst_n),
      .i_M0_Req      (m_req[0]),
      .i_M0_Wr_Rd_n  (m_wr[0]),
      .i_M0_Addr8    (m_addr[0]),
      .i_M0_Wr_Data  (m_wdata[0]),
      .o_M0_Ack      (ack0),
      .o_M0_Err      (err0),
      .o_M0_Rd_Data  (rd0),
      .i_M1_Req      (m_req[1]),
      .i_M1_Wr_Rd_n  (m_wr[1]),
      .i_M1_Addr8    (m_addr[1]),
      .i_M1_Wr_Data  (m_wdata[1]),
      .o_M1_Ack      (ack1),
      .o_M1_Err      (err1),
      .o_M1_Rd_Data  (rd1),
      .o_Bus_CS      (cs),
      .o_Bus_Wr_Rd_n (bwr),
      .o_Bus_Addr8   (baddr),
      .o_Bus_Wr_Data (bwdata),
      .i_Bus_Rd_Data (brdata),
      .i_Bus_Rd_DV   (bdv)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic q0, q1, w0, w1, input logic [4:0] a0, a1,
                               input logic [15:0] d0, d1, input int v0, v1,
                               input logic [15:0] r0, r1, input int nrep,
                               input logic stray, input int ef, el);
      vec_t v;
      v.req0 = q0; v.req1 = q1; v.wr0 = w0; v.wr1 = w1;
      v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
      v.dvd0 = v0; v.dvd1 = v1; v.rdata0 = r0; v.rdata1 = r1;
      v.nrep = nrep; v.stray = stray; v.exp_first = ef; v.exp_lat = el;
      return v;
   endfunction

   // Round-robin choice among pending masters.
   function automatic int pick(input logic p0, p1, input int last);
      if (p0 && p1) return (last == 0) ? 1 : 0;
      return p1 ? 1 : 0;
   endfunction

   // Completion timing and result of a granted transaction starting at cycle t0.
   task automatic plan(input int g, input int t0, input logic wr, input int dvd,
                       input logic [15:0] rdata, output int ack_cyc, output logic err,
                       output logic [15:0] data);
      if (wr) begin
         ack_cyc = t0 + 2; err = 1'b0; data = rd_hold[g];
      end else if (dvd >= 1 && dvd <= T) begin
         ack_cyc = t0 + 2 + dvd; err = 1'b0; data = rdata;
      end else begin
         ack_cyc = t0 + T + 2; err = 1'b1; data = 16'h0000;
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctl"}, 32'({ack0, ack1, err0, err1, cs, bwr}), 32'd0);
      chk({tag, "_addr"}, 32'(baddr), 32'd0);
      chk({tag, "_wdata"}, 32'(bwdata), 32'd0);
      chk({tag, "_rd0"}, 32'(rd0), 32'd0);
      chk({tag, "_rd1"}, 32'(rd1), 32'd0);
   endtask

   // Called at a negedge with the DUT idle; that cycle is cycle 0.
   task automatic run_vec(input vec_t v);
      int          rem [2];
      int          dvd [2];
      logic [15:0] rdat [2];
      logic        rr [2];
      int          g, t0, ack_cyc, dv_cyc, done_cyc;
      logic        exp_err, busy, first;
      logic [15:0] exp_data, dv_data;
      logic        ea0, ea1;

      rem[0] = v.req0 ? v.nrep : 0;
      rem[1] = v.req1 ? v.nrep : 0;
      dvd[0] = v.dvd0;  dvd[1] = v.dvd1;
      rdat[0] = v.rdata0; rdat[1] = v.rdata1;
      m_wr[0] = v.wr0;  m_wr[1] = v.wr1;
      m_addr[0] = v.addr0; m_addr[1] = v.addr1;
      m_wdata[0] = v.wdata0; m_wdata[1] = v.wdata1;
      m_req[0] = (rem[0] > 0);
      m_req[1] = (rem[1] > 0);
      bdv = v.stray;
      brdata = 16'($urandom);
      rr[0] = 1'b0; rr[1] = 1'b0;
      first = 1'b1; dv_cyc = -1; done_cyc = 0; dv_data = 16'h0;
      g = 0; t0 = 0; ack_cyc = 0; exp_err = 1'b0; exp_data = 16'h0;
      busy = m_req[0] || m_req[1];
      if (busy) begin
         g = pick(m_req[0], m_req[1], model_last);
         model_last = g;
         plan(g, 0, m_wr[g], dvd[g], rdat[g], ack_cyc, exp_err, exp_data);
      end

      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (rr[0]) m_req[0] = 1'b1;
         if (rr[1]) m_req[1] = 1'b1;
         rr[0] = 1'b0; rr[1] = 1'b0;

         chk("cs", 32'(cs), 32'(busy && cyc == t0 + 1));
         if (busy && cyc == t0 + 1) begin
            hold_wr = m_wr[g]; hold_addr = m_addr[g]; hold_wdata = m_wdata[g];
            if (!m_wr[g] && dvd[g] > 0) begin
               dv_cyc = cyc + dvd[g];
               dv_data = rdat[g];
            end
         end
         chk("bus_wr", 32'(bwr), 32'(hold_wr));
         chk("bus_addr", 32'(baddr), 32'(hold_addr));
         chk("bus_wdata", 32'(bwdata), 32'(hold_wdata));

         ea0 = busy && cyc == ack_cyc && g == 0;
         ea1 = busy && cyc == ack_cyc && g == 1;
         chk("ack0", 32'(ack0), 32'(ea0));
         chk("ack1", 32'(ack1), 32'(ea1));
         if (first && v.exp_first >= 0 && (ack0 || ack1)) begin
            chk("first_master", ack1 ? 32'd1 : 32'd0, 32'(v.exp_first));
            chk("first_latency", 32'(cyc), 32'(v.exp_lat));
            first = 1'b0;
         end

         if (busy && cyc == ack_cyc) begin
            chk("err", 32'(g == 1 ? err1 : err0), 32'(exp_err));
            rd_hold[g] = exp_data;
            m_req[g] = 1'b0;
            rem[g]--;
            rr[g] = (rem[g] > 0);
            if (rr[0] || rr[1] || m_req[0] || m_req[1]) begin
               g = pick(m_req[0] || rr[0], m_req[1] || rr[1], model_last);
               model_last = g;
               t0 = cyc + 1;
               plan(g, t0, m_wr[g], dvd[g], rdat[g], ack_cyc, exp_err, exp_data);
            end else begin
               busy = 1'b0;
               done_cyc = cyc;
            end
         end
         chk("rd0", 32'(rd0), 32'(rd_hold[0]));
         chk("rd1", 32'(rd1), 32'(rd_hold[1]));

         bdv = (cyc == dv_cyc);
         brdata = bdv ? dv_data : 16'($urandom);

         if (!busy && cyc >= done_cyc + 2) break;
      end
      chk("txn_complete", 32'(busy), 32'd0);
      bdv = 1'b0;
   endtask

   vec_t tbl [8];
   vec_t rv;

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_req[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; rd_hold[i] = '0;
      end
      bdv = 1'b0; brdata = '0;
      model_last = 1;
      hold_wr = 1'b0; hold_addr = '0; hold_wdata = '0;

      //        q0 q1 w0 w1 a0     a1     d0        d1        v0  v1  r0        r1     n st ef lat
      tbl[0] = mk(1, 0, 1, 0, 5'h04, 5'h00, 16'hA5A5, 16'h0000, 0,  0,  16'h0000, 16'h0, 1, 0, 0, 2);
      tbl[1] = mk(0, 1, 0, 0, 5'h00, 5'h1E, 16'h0000, 16'h0000, 0,  1,  16'h0000, 16'h1234,
                  1, 0, 1, 3);
      tbl[2] = mk(1, 1, 1, 1, 5'h01, 5'h02, 16'h1111, 16'h2222, 0,  0,  16'h0000, 16'h0, 2, 0, 0, 2);
      tbl[3] = mk(1, 0, 0, 0, 5'h07, 5'h00, 16'h0000, 16'h0000, 2,  0,  16'h5A5A, 16'h0, 1, 0, 0, 4);
      tbl[4] = mk(1, 0, 0, 0, 5'h10, 5'h00, 16'h0000, 16'h0000, 0,  0,  16'h0000, 16'h0, 1, 0, 0, 17);
      tbl[5] = mk(0, 1, 0, 0, 5'h00, 5'h0C, 16'h0000, 16'h0000, 0,  T,  16'h0000, 16'hBEEF,
                  1, 1, 1, 17);
      tbl[6] = mk(0, 0, 0, 0, 5'h00, 5'h00, 16'h0000, 16'h0000, 0,  0,  16'h0000, 16'h0, 1, 1, -1, 0);
      tbl[7] = mk(1, 1, 0, 1, 5'h15, 5'h03, 16'h0000, 16'hC3C3, 16, 0,  16'h7777, 16'h0, 1, 0, 0, 17);

      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // Reset while M0 waits for read data.
      m_req[0] = 1'b1; m_wr[0] = 1'b0; m_addr[0] = 5'h0A;
      repeat (4) @(negedge clk);
      chk("pre_reset_cs", 32'(cs), 32'd0);
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("mid_reset");
      m_req[0] = 1'b0;
      model_last = 1;
      rd_hold[0] = '0; rd_hold[1] = '0;
      hold_wr = 1'b0; hold_addr = '0; hold_wdata = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_ack", 32'({ack0, ack1}), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_quiet", 32'({ack0, ack1, cs}), 32'd0);
      end
      run_vec(mk(1, 1, 1, 1, 5'h08, 5'h09, 16'hABCD, 16'h4321, 0, 0, 16'h0, 16'h0, 1, 0, 0, 2));

      for (int i = 0; i < 30; i++) begin
         rv = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 5'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, T + 2)),
                 int'($urandom_range(0, T + 2)), 16'($urandom), 16'($urandom),
                 int'($urandom_range(1, 2)), 1'($urandom), -1, 0);
         run_vec(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
